// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: forwarding and hazard unit for the pipelined MIPS core.
// A shift-register scoreboard holds one entry per post-ID stage (stage 0 = EX).
// From it the unit drives the EX and ID forwarding selects and a load-use or
// branch stall.
// Optional build macro FWD_PERF_CNT_EN adds a saturating 16-bit stall_count output.
module fwd_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int REG_W      = 5,
    parameter int SEL_W      = $clog2(DEPTH + 1),
    parameter int LOAD_READY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             id_branch,
    input  logic             id_flush,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    output logic [SEL_W-1:0] ex_muxA,
    output logic [SEL_W-1:0] ex_muxB,
    output logic [SEL_W-1:0] id_muxA,
    output logic [SEL_W-1:0] id_muxB,
    output logic             stall
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [15:0]      stall_count
`endif
);

    // Scoreboard: index k is the instruction currently in post-ID stage k.
    logic [DEPTH-1:0] sb_vld;
    logic [DEPTH-1:0] sb_load;
    logic [REG_W-1:0] sb_rd [DEPTH];

    // Sources are handled as pairs so rs and rt share one lookup loop.
    logic [REG_W-1:0] ex_src [2];
    logic [REG_W-1:0] id_src [2];
    logic [SEL_W-1:0] ex_sel [2];
    logic [SEL_W-1:0] id_sel [2];
    logic [1:0]       id_stall;

    assign ex_src[0] = ex_rs;
    assign ex_src[1] = ex_rt;
    assign id_src[0] = id_rs;
    assign id_src[1] = id_rt;

    // Youngest-match lookup for EX and ID operands, with the readiness test.
    always_comb begin
        logic ex_hit;
        logic id_hit;
        int   rdy_lvl;
        ex_hit   = 1'b0;
        id_hit   = 1'b0;
        rdy_lvl  = 0;
        id_stall = '0;
        for (int s = 0; s < 2; s++) begin
            ex_sel[s] = '0;
            id_sel[s] = '0;
            ex_hit    = 1'b0;
            id_hit    = 1'b0;
            // Stage 0 is the EX instruction itself, so the EX search starts at stage 1.
            for (int k = 1; k < DEPTH; k++) begin
                if (!ex_hit && sb_vld[k] && sb_rd[k] == ex_src[s] && ex_src[s] != '0) begin
                    ex_hit    = 1'b1;
                    ex_sel[s] = SEL_W'(k);
                end
            end
            // Only the youngest match counts; older entries with the same rd are shadowed.
            for (int k = 0; k < DEPTH; k++) begin
                if (!id_hit && sb_vld[k] && sb_rd[k] == id_src[s] && id_src[s] != '0) begin
                    id_hit  = 1'b1;
                    rdy_lvl = sb_load[k] ? LOAD_READY : 1;
                    if (id_branch) begin
                        if (k >= rdy_lvl)
                            id_sel[s] = SEL_W'(k);
                        else
                            id_stall[s] = 1'b1;
                    end else if (k + 1 < rdy_lvl) begin
                        // The producer will still not be ready once the consumer reaches EX.
                        id_stall[s] = 1'b1;
                    end
                end
            end
        end
    end

    assign ex_muxA = ex_sel[0];
    assign ex_muxB = ex_sel[1];
    assign id_muxA = id_sel[0];
    assign id_muxB = id_sel[1];
    assign stall   = |id_stall;

    // Shift the valid bits; a stalled or flushed ID instruction becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_vld <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--)
                sb_vld[k] <= sb_vld[k-1];
            sb_vld[0] <= !stall && !id_flush && id_regWrite && (id_rd != '0);
        end
    end

    // Shift the entry payload; it is only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
            sb_rd[k]   <= sb_rd[k-1];
            sb_load[k] <= sb_load[k-1];
        end
        sb_rd[0]   <= id_rd;
        sb_load[0] <= id_memRead;
    end

`ifdef FWD_PERF_CNT_EN
    // Count cycles lost to stalls; a flushed cycle is not counted, and the count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (stall && !id_flush && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif

endmodule
